calc_seq_ctrl: RTL and testbench
================================

# calc_seq_ctrl

Keypad-driven sequencer for the 4-digit BCD calculator datapath. Accepts single-cycle key strobes (digits, +, −, =, clear) and builds two BCD operands by nibble shifting. It drives the combinational saturating BCD add/sub ALU, captures the result and supports chained and repeated operations. It sits between the key decoder and the ALU/7-segment display driver.

## Interface
- No parameters. Width is fixed at 4 BCD digits (16 bits).
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- key_valid  in  1  one-cycle strobe; key_code is valid when high.
- key_code  in  4  0–9 digit; 4'hA add; 4'hB sub; 4'hC equals; 4'hD clear; 4'hE/4'hF ignored.
- key_ready  out  1  high when a strobe this cycle will be accepted.
- alu_num1  out  16  operand A to the ALU (BCD).
- alu_num2  out  16  operand B to the ALU (BCD).
- alu_op  out  2  2'b01 add, 2'b10 sub.
- alu_result  in  16  combinational ALU output (BCD, already saturated to 0000/9999).
- display_bcd  out  16  value for the display driver.
- result_valid  out  1  one-cycle pulse when a result is captured.

## Operation
- Registers:
  - a_reg, b_reg: 16 bits each.
  - a_cnt, b_cnt: 0..4 digit counts.
  - op_reg: 2 bits.
  - chain_op: 2 bits, plus chain_pend flag.
- Outputs driven directly from registers: alu_num1=a_reg, alu_num2=b_reg, alu_op=op_reg.
- FSM states: S_A, S_OP, S_B, S_EXEC, S_RES.
- Key classes:
  - Digit: 0–9.
  - Op: A (op=01) or B (op=10).
  - Equals: C.
  - Clear: D.
- Digit shift rule: x = {x[11:0], d}, cnt+1, applied only when cnt<4. A fifth and later digit is dropped; the register is unchanged.
- S_A:
  - Digit: shift into a_reg; display=a_reg (new value).
  - Op: op_reg=op; go S_OP.
  - Equals: ignored.
- S_OP:
  - Digit: b_reg=d, b_cnt=1; display=d; go S_B.
  - Op: overwrites op_reg.
  - Equals: ignored.
- S_B:
  - Digit: shift into b_reg; display=b_reg.
  - Equals: chain_pend=0; go S_EXEC.
  - Op: chain_op=op, chain_pend=1; go S_EXEC.
- S_EXEC (exactly one cycle):
  - a_reg and display capture alu_result; result_valid=1.
  - If chain_pend: op_reg=chain_op, chain_pend=0, a_cnt=4; go S_OP.
  - Otherwise go S_RES.
  - b_reg is retained.
- S_RES:
  - Digit: a_reg=d, a_cnt=1, b cleared; display=d; go S_A.
  - Op: op_reg=op; go S_OP. The result is operand A.
  - Equals: go S_EXEC with unchanged b_reg/op_reg (repeat last operation).
- Clear (D) in any state, including S_EXEC:
  - a_reg=b_reg=0, counts=0, op_reg=01, chain_pend=0, display=0; go S_A.
  - Clear has priority over EXEC capture.
  - result_valid=0 that cycle.
- key_ready=0 only in S_EXEC. Strobes other than clear in that cycle are dropped, not queued.
- Codes E/F are no-ops in every state.
- Overflow/underflow is handled by the ALU (9999/0000). The controller passes the value through unchanged.

## Timing
- Reset (rst_n low at a rising edge):
  - State S_A; a_reg=b_reg=0; counts=0; op_reg=2'b01; chain_pend=0.
  - display_bcd=0, result_valid=0, alu_num1=alu_num2=0, alu_op=2'b01, key_ready=1.
- Reset asserted mid-operation, including in S_EXEC, aborts without capturing alu_result.
- Key strobe sampled at edge k: register, display and state updates are visible in cycle k+1.
- Equals or op sampled at edge k:
  - S_EXEC is the state during cycle k+1.
  - Result captured at edge k+1.
  - display_bcd and result_valid are visible in cycle k+2; result_valid is high for that one cycle only.
- ALU path is combinational: alu_num1/alu_num2/alu_op must be stable for the whole S_EXEC cycle. They change only on key acceptance or capture.
- Back-to-back strobes every cycle are legal. The strobe landing in the S_EXEC cycle is dropped (key_ready=0).

## Test plan
- Basic add, with display checked at each step:
  - Reset, keys 1,2,A,3,4,C.
  - display 0001→0012→0012→0003→0034→0046.
  - result_valid pulses once, 2 cycles after C.
- Subtract saturation and repeat:
  - Keys 5,B,9,C → display 0000.
  - Keys 1,0,0,A,1,C → 0101.
  - C again → 0102; C again → 0103.
- Digit limit and overflow:
  - Keys 9,9,9,9,9 → a_reg 9999 (fifth digit dropped).
  - Then A,1,C → display 9999.
- Chaining:
  - Keys 8,A,7,B → result 0015 captured; state S_OP with alu_op=10.
  - Then 5,C → 0010.
- Drop and clear:
  - Keys 2,A,3,C, then digit 4 in the S_EXEC cycle: key_ready=0, display ends at 0005, next state S_RES.
  - Clear during S_EXEC → display 0000, no result_valid, state S_A.
- Reset mid-entry:
  - Keys 1,A,2, then rst_n low one cycle.
  - All outputs at reset values.
  - Keys 3,C → display stays 0003.

Source files
------------

// File: rtl/calc_seq_ctrl_if.sv
// rtl/calc_seq_ctrl_if.sv - key strobe, ALU and display bundle for the calculator sequencer
//
// Signals:
//   key_valid    one-cycle key strobe from the key decoder
//   key_code     0-9 digit, A add, B sub, C equals, D clear, E/F ignored
//   key_ready    high when a strobe this cycle will be accepted
//   alu_num1     operand A to the combinational BCD ALU
//   alu_num2     operand B to the combinational BCD ALU
//   alu_op       01 add, 10 sub
//   alu_result   saturated BCD result from the ALU
//   display_bcd  value shown by the 7-segment driver
//   result_valid one-cycle pulse when a result is captured
// Modports: slave = sequencer, master = key decoder / ALU / display side.

interface calc_seq_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [15:0] alu_num1;
    logic [15:0] alu_num2;
    logic [1:0]  alu_op;
    logic [15:0] alu_result;
    logic [15:0] display_bcd;
    logic        result_valid;

    modport slave (
        input  key_valid, key_code, alu_result,
        output key_ready, alu_num1, alu_num2, alu_op, display_bcd, result_valid
    );

    modport master (
        output key_valid, key_code, alu_result,
        input  key_ready, alu_num1, alu_num2, alu_op, display_bcd, result_valid
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - keypad sequencer for the 4-digit BCD add/sub calculator
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    calc_seq_ctrl_if.slave: key strobes in, ALU operands/op out,
//          ALU result in, display value and result pulse out
//
// Operands are built by shifting BCD digits in from the right (max 4 digits).
// Equals or an operator after operand B launches a one-cycle S_EXEC in which
// the combinational ALU result is captured into operand A. An operator there
// chains: the new operator is held and applied after the capture.

module calc_seq_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    calc_seq_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    state_t      state, state_nxt;
    logic [15:0] a_reg, a_nxt;
    logic [15:0] b_reg, b_nxt;
    logic [2:0]  a_cnt, a_cnt_nxt;
    logic [2:0]  b_cnt, b_cnt_nxt;
    logic [1:0]  op_reg, op_nxt;
    logic [1:0]  chain_op, chain_op_nxt;
    logic        chain_pend, chain_pend_nxt;
    logic [15:0] display, display_nxt;
    logic        res_valid, res_valid_nxt;

    logic        is_digit, is_op, is_eq, is_clr;
    logic [1:0]  key_op;
    logic [15:0] digit_ext;

    always_comb begin
        is_digit  = bus.key_valid && (bus.key_code <= 4'd9);
        is_op     = bus.key_valid && ((bus.key_code == 4'hA) || (bus.key_code == 4'hB));
        is_eq     = bus.key_valid && (bus.key_code == 4'hC);
        is_clr    = bus.key_valid && (bus.key_code == 4'hD);
        key_op    = (bus.key_code == 4'hA) ? OP_ADD : OP_SUB;
        digit_ext = {12'h000, bus.key_code};
    end

    always_comb begin
        state_nxt      = state;
        a_nxt          = a_reg;
        b_nxt          = b_reg;
        a_cnt_nxt      = a_cnt;
        b_cnt_nxt      = b_cnt;
        op_nxt         = op_reg;
        chain_op_nxt   = chain_op;
        chain_pend_nxt = chain_pend;
        display_nxt    = display;
        res_valid_nxt  = 1'b0;

        if (is_clr) begin
            // Clear wins over everything, including the S_EXEC capture.
            state_nxt      = S_A;
            a_nxt          = 16'h0000;
            b_nxt          = 16'h0000;
            a_cnt_nxt      = 3'd0;
            b_cnt_nxt      = 3'd0;
            op_nxt         = OP_ADD;
            chain_pend_nxt = 1'b0;
            display_nxt    = 16'h0000;
        end else begin
            unique case (state)
                S_A: begin
                    if (is_digit) begin
                        if (a_cnt < 3'd4) begin
                            a_nxt     = {a_reg[11:0], bus.key_code};
                            a_cnt_nxt = a_cnt + 3'd1;
                        end
                        display_nxt = a_nxt;
                    end else if (is_op) begin
                        op_nxt    = key_op;
                        state_nxt = S_OP;
                    end
                end
                S_OP: begin
                    if (is_digit) begin
                        b_nxt       = digit_ext;
                        b_cnt_nxt   = 3'd1;
                        display_nxt = digit_ext;
                        state_nxt   = S_B;
                    end else if (is_op) begin
                        op_nxt = key_op;
                    end
                end
                S_B: begin
                    if (is_digit) begin
                        if (b_cnt < 3'd4) begin
                            b_nxt     = {b_reg[11:0], bus.key_code};
                            b_cnt_nxt = b_cnt + 3'd1;
                        end
                        display_nxt = b_nxt;
                    end else if (is_eq) begin
                        chain_pend_nxt = 1'b0;
                        state_nxt      = S_EXEC;
                    end else if (is_op) begin
                        chain_op_nxt   = key_op;
                        chain_pend_nxt = 1'b1;
                        state_nxt      = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Non-clear strobes here are dropped (key_ready is low).
                    a_nxt         = bus.alu_result;
                    display_nxt   = bus.alu_result;
                    res_valid_nxt = 1'b1;
                    if (chain_pend) begin
                        op_nxt         = chain_op;
                        chain_pend_nxt = 1'b0;
                        // Result is a full operand; no further digits append to it.
                        a_cnt_nxt      = 3'd4;
                        state_nxt      = S_OP;
                    end else begin
                        state_nxt = S_RES;
                    end
                end
                S_RES: begin
                    if (is_digit) begin
                        a_nxt       = digit_ext;
                        a_cnt_nxt   = 3'd1;
                        b_nxt       = 16'h0000;
                        b_cnt_nxt   = 3'd0;
                        display_nxt = digit_ext;
                        state_nxt   = S_A;
                    end else if (is_op) begin
                        op_nxt    = key_op;
                        state_nxt = S_OP;
                    end else if (is_eq) begin
                        // Repeat the last operation with the retained b_reg/op_reg.
                        state_nxt = S_EXEC;
                    end
                end
                default: state_nxt = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_A;
            a_reg      <= 16'h0000;
            b_reg      <= 16'h0000;
            a_cnt      <= 3'd0;
            b_cnt      <= 3'd0;
            op_reg     <= OP_ADD;
            chain_op   <= OP_ADD;
            chain_pend <= 1'b0;
            display    <= 16'h0000;
            res_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            a_reg      <= a_nxt;
            b_reg      <= b_nxt;
            a_cnt      <= a_cnt_nxt;
            b_cnt      <= b_cnt_nxt;
            op_reg     <= op_nxt;
            chain_op   <= chain_op_nxt;
            chain_pend <= chain_pend_nxt;
            display    <= display_nxt;
            res_valid  <= res_valid_nxt;
        end
    end

    assign bus.key_ready    = (state != S_EXEC);
    assign bus.alu_num1     = a_reg;
    assign bus.alu_num2     = b_reg;
    assign bus.alu_op       = op_reg;
    assign bus.display_bcd  = display;
    assign bus.result_valid = res_valid;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - directed self-checking bench for calc_seq_ctrl

module tb_calc_seq_ctrl;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    calc_seq_ctrl_if bus ();

    calc_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Saturating 4-digit BCD add/sub ALU environment.
    function automatic int bcd2int(input logic [15:0] x);
        return x[15:12] * 1000 + x[11:8] * 100 + x[7:4] * 10 + x[3:0];
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [15:0] alu(input logic [15:0] n1, input logic [15:0] n2,
                                        input logic [1:0] op);
        int r;
        if (op == 2'b10) r = bcd2int(n1) - bcd2int(n2);
        else             r = bcd2int(n1) + bcd2int(n2);
        if (r < 0)    r = 0;
        if (r > 9999) r = 9999;
        return int2bcd(r);
    endfunction

    assign bus.alu_result = alu(bus.alu_num1, bus.alu_num2, bus.alu_op);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'hE;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        compared++; if (bus.display_bcd !== 16'h0000) begin mismatched++; $display("FAIL reset_display got %h exp 0000", bus.display_bcd); end
        compared++; if (bus.result_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rv got %b exp 0", bus.result_valid); end
        compared++; if (bus.alu_num1 !== 16'h0000) begin mismatched++; $display("FAIL reset_num1 got %h exp 0000", bus.alu_num1); end
        compared++; if (bus.alu_num2 !== 16'h0000) begin mismatched++; $display("FAIL reset_num2 got %h exp 0000", bus.alu_num2); end
        compared++; if (bus.alu_op !== 2'b01) begin mismatched++; $display("FAIL reset_op got %b exp 01", bus.alu_op); end
        compared++; if (bus.key_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b exp 1", bus.key_ready); end
    endtask

    task automatic test_basic_add();
        press(4'h1);
        compared++; if (bus.display_bcd !== 16'h0001) begin mismatched++; $display("FAIL add_d1 got %h exp 0001", bus.display_bcd); end
        press(4'h2);
        compared++; if (bus.display_bcd !== 16'h0012) begin mismatched++; $display("FAIL add_d2 got %h exp 0012", bus.display_bcd); end
        press(4'hA);
        compared++; if (bus.display_bcd !== 16'h0012) begin mismatched++; $display("FAIL add_op_disp got %h exp 0012", bus.display_bcd); end
        compared++; if (bus.alu_op !== 2'b01) begin mismatched++; $display("FAIL add_op got %b exp 01", bus.alu_op); end
        press(4'h3);
        compared++; if (bus.display_bcd !== 16'h0003) begin mismatched++; $display("FAIL add_d3 got %h exp 0003", bus.display_bcd); end
        press(4'h4);
        compared++; if (bus.display_bcd !== 16'h0034) begin mismatched++; $display("FAIL add_d4 got %h exp 0034", bus.display_bcd); end
        compared++; if (bus.alu_num1 !== 16'h0012 || bus.alu_num2 !== 16'h0034) begin mismatched++; $display("FAIL add_operands got %h/%h exp 0012/0034", bus.alu_num1, bus.alu_num2); end
        press(4'hC);
        compared++; if (bus.key_ready !== 1'b0) begin mismatched++; $display("FAIL add_exec_ready got %b exp 0", bus.key_ready); end
        compared++; if (bus.result_valid !== 1'b0) begin mismatched++; $display("FAIL add_rv_early got %b exp 0", bus.result_valid); end
        tick();
        compared++; if (bus.display_bcd !== 16'h0046) begin mismatched++; $display("FAIL add_result got %h exp 0046", bus.display_bcd); end
        compared++; if (bus.result_valid !== 1'b1) begin mismatched++; $display("FAIL add_rv got %b exp 1", bus.result_valid); end
        tick();
        compared++; if (bus.result_valid !== 1'b0) begin mismatched++; $display("FAIL add_rv_late got %b exp 0", bus.result_valid); end
        compared++; if (bus.key_ready !== 1'b1) begin mismatched++; $display("FAIL add_ready_back got %b exp 1", bus.key_ready); end
    endtask

    task automatic test_sub_repeat();
        press(4'hD);
        press(4'h5); press(4'hB); press(4'h9); press(4'hC); tick();
        compared++; if (bus.display_bcd !== 16'h0000) begin mismatched++; $display("FAIL sub_sat got %h exp 0000", bus.display_bcd); end
        compared++; if (bus.result_valid !== 1'b1) begin mismatched++; $display("FAIL sub_rv got %b exp 1", bus.result_valid); end
        press(4'h1); press(4'h0); press(4'h0);
        compared++; if (bus.display_bcd !== 16'h0100) begin mismatched++; $display("FAIL res_newa got %h exp 0100", bus.display_bcd); end
        press(4'hA); press(4'h1); press(4'hC); tick();
        compared++; if (bus.display_bcd !== 16'h0101) begin mismatched++; $display("FAIL add_101 got %h exp 0101", bus.display_bcd); end
        press(4'hC); tick();
        compared++; if (bus.display_bcd !== 16'h0102) begin mismatched++; $display("FAIL repeat1 got %h exp 0102", bus.display_bcd); end
        press(4'hC); tick();
        compared++; if (bus.display_bcd !== 16'h0103) begin mismatched++; $display("FAIL repeat2 got %h exp 0103", bus.display_bcd); end
    endtask

    task automatic test_digit_limit();
        press(4'hD);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        compared++; if (bus.alu_num1 !== 16'h1234) begin mismatched++; $display("FAIL limit_1234 got %h exp 1234", bus.alu_num1); end
        compared++; if (bus.display_bcd !== 16'h1234) begin mismatched++; $display("FAIL limit_disp got %h exp 1234", bus.display_bcd); end
        press(4'hF);
        compared++; if (bus.alu_num1 !== 16'h1234) begin mismatched++; $display("FAIL code_f_noop got %h exp 1234", bus.alu_num1); end
        press(4'hD);
        for (int i = 0; i < 5; i++) press(4'h9);
        compared++; if (bus.alu_num1 !== 16'h9999) begin mismatched++; $display("FAIL limit_9999 got %h exp 9999", bus.alu_num1); end
        press(4'hA); press(4'h1); press(4'hC); tick();
        compared++; if (bus.display_bcd !== 16'h9999) begin mismatched++; $display("FAIL overflow got %h exp 9999", bus.display_bcd); end
    endtask

    task automatic test_chain();
        press(4'hD);
        press(4'h8); press(4'hA); press(4'h7); press(4'hB);
        compared++; if (bus.key_ready !== 1'b0) begin mismatched++; $display("FAIL chain_exec got %b exp 0", bus.key_ready); end
        tick();
        compared++; if (bus.display_bcd !== 16'h0015) begin mismatched++; $display("FAIL chain_mid got %h exp 0015", bus.display_bcd); end
        compared++; if (bus.result_valid !== 1'b1) begin mismatched++; $display("FAIL chain_rv got %b exp 1", bus.result_valid); end
        compared++; if (bus.alu_op !== 2'b10) begin mismatched++; $display("FAIL chain_op got %b exp 10", bus.alu_op); end
        press(4'h5);
        compared++; if (bus.alu_num2 !== 16'h0005 || bus.display_bcd !== 16'h0005) begin mismatched++; $display("FAIL chain_b got %h/%h exp 0005/0005", bus.alu_num2, bus.display_bcd); end
        press(4'hC); tick();
        compared++; if (bus.display_bcd !== 16'h0010) begin mismatched++; $display("FAIL chain_final got %h exp 0010", bus.display_bcd); end
    endtask

    task automatic test_drop_clear();
        press(4'hD);
        press(4'h2); press(4'hA); press(4'h3); press(4'hC);
        compared++; if (bus.key_ready !== 1'b0) begin mismatched++; $display("FAIL drop_ready got %b exp 0", bus.key_ready); end
        bus.key_valid = 1'b1; bus.key_code = 4'h4;
        tick();
        bus.key_valid = 1'b0; bus.key_code = 4'hE;
        compared++; if (bus.display_bcd !== 16'h0005) begin mismatched++; $display("FAIL drop_disp got %h exp 0005", bus.display_bcd); end
        compared++; if (bus.result_valid !== 1'b1) begin mismatched++; $display("FAIL drop_rv got %b exp 1", bus.result_valid); end
        press(4'hC); tick();
        compared++; if (bus.display_bcd !== 16'h0008) begin mismatched++; $display("FAIL drop_res_state got %h exp 0008", bus.display_bcd); end
        press(4'hD);
        press(4'h2); press(4'hA); press(4'h3); press(4'hC);
        bus.key_valid = 1'b1; bus.key_code = 4'hD;
        tick();
        bus.key_valid = 1'b0; bus.key_code = 4'hE;
        compared++; if (bus.display_bcd !== 16'h0000) begin mismatched++; $display("FAIL clr_exec_disp got %h exp 0000", bus.display_bcd); end
        compared++; if (bus.result_valid !== 1'b0) begin mismatched++; $display("FAIL clr_exec_rv got %b exp 0", bus.result_valid); end
        compared++; if (bus.alu_num1 !== 16'h0000 || bus.alu_num2 !== 16'h0000 || bus.alu_op !== 2'b01) begin mismatched++; $display("FAIL clr_exec_regs got %h/%h/%b exp 0000/0000/01", bus.alu_num1, bus.alu_num2, bus.alu_op); end
        compared++; if (bus.key_ready !== 1'b1) begin mismatched++; $display("FAIL clr_exec_ready got %b exp 1", bus.key_ready); end
        press(4'h7); press(4'h2);
        compared++; if (bus.display_bcd !== 16'h0072) begin mismatched++; $display("FAIL clr_state_a got %h exp 0072", bus.display_bcd); end
        press(4'hA); press(4'h1); press(4'hC); tick();
        compared++; if (bus.display_bcd !== 16'h0073) begin mismatched++; $display("FAIL clr_after got %h exp 0073", bus.display_bcd); end
    endtask

    task automatic test_reset_mid();
        press(4'hD);
        press(4'h1); press(4'hA); press(4'h2);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        compared++; if (bus.display_bcd !== 16'h0000 || bus.result_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_disp got %h/%b exp 0000/0", bus.display_bcd, bus.result_valid); end
        compared++; if (bus.alu_num1 !== 16'h0000 || bus.alu_num2 !== 16'h0000 || bus.alu_op !== 2'b01) begin mismatched++; $display("FAIL rstmid_regs got %h/%h/%b exp 0000/0000/01", bus.alu_num1, bus.alu_num2, bus.alu_op); end
        compared++; if (bus.key_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_ready got %b exp 1", bus.key_ready); end
        press(4'h3);
        compared++; if (bus.display_bcd !== 16'h0003) begin mismatched++; $display("FAIL rstmid_d3 got %h exp 0003", bus.display_bcd); end
        press(4'hC);
        compared++; if (bus.key_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_eq_ignored got %b exp 1", bus.key_ready); end
        tick();
        compared++; if (bus.display_bcd !== 16'h0003 || bus.result_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_final got %h/%b exp 0003/0", bus.display_bcd, bus.result_valid); end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst_n         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'hE;
        test_reset();
        test_basic_add();
        test_sub_repeat();
        test_digit_limit();
        test_chain();
        test_drop_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
